// File: rtl/bnn_sign_pool.sv
// Sign activation of per-kernel convolution sums, pooled over POOL frames, one binary vector per window.
// Define BNN_SIGN_POOL_MAJ_EN for majority pooling; the default build uses max (OR) pooling.
`timescale 1ns/1ps

module bnn_sign_pool #(
    parameter int NUM_K  = 3,
    parameter int SUM_W  = 4,
    parameter int POOL   = 2,
    parameter int FRAMES = 6,
    parameter int THRESH = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_K*SUM_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_K-1:0]       out_data,
    output logic                   out_last
);

    localparam int SAFE_POOL = (POOL < 1) ? 1 : POOL;
    localparam int WINDOWS   = (FRAMES / SAFE_POOL < 1) ? 1 : FRAMES / SAFE_POOL;
    localparam int PCW       = (SAFE_POOL > 1) ? $clog2(SAFE_POOL) : 1;
    localparam int WCW       = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;
    localparam logic signed [SUM_W-1:0] THR = SUM_W'(THRESH);

    generate
        if (POOL < 1) begin : g_bad_pool
            $error("bnn_sign_pool: POOL must be at least 1");
        end
        if ((FRAMES % SAFE_POOL) != 0 || FRAMES < SAFE_POOL) begin : g_bad_frames
            $error("bnn_sign_pool: FRAMES must be a non-zero multiple of POOL");
        end
    endgenerate

    logic [PCW-1:0]   pool_cnt_reg;
    logic [WCW-1:0]   win_cnt_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [NUM_K-1:0] out_data_reg;
    logic [NUM_K-1:0] bits;
    logic [NUM_K-1:0] pooled;
    logic             accept;
    logic             complete;
    logic             win_last;

    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    // A beat that arrives together with clear is swallowed and never completes a window.
    assign complete  = accept && !clear && (pool_cnt_reg == PCW'(SAFE_POOL - 1));
    assign win_last  = (win_cnt_reg == WCW'(WINDOWS - 1));

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_K; gi++) begin : g_act
            logic signed [SUM_W-1:0] sum;
            assign sum      = in_data[gi*SUM_W +: SUM_W];
            assign bits[gi] = (sum >= THR);
        end
    endgenerate

`ifdef BNN_SIGN_POOL_MAJ_EN
    localparam int CW = $clog2(SAFE_POOL + 1);

    logic [NUM_K-1:0][CW-1:0] cnt_reg;
    logic [NUM_K-1:0][CW:0]   cnt_sum;

    // Count including the current beat; the window result is a strict majority, ties fall to 0.
    generate
        for (gi = 0; gi < NUM_K; gi++) begin : g_maj
            assign cnt_sum[gi] = {1'b0, cnt_reg[gi]} + (CW+1)'(bits[gi]);
            assign pooled[gi]  = {cnt_sum[gi], 1'b0} > (CW+2)'(SAFE_POOL);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear || complete) begin
            cnt_reg <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_K; k++) begin
                cnt_reg[k] <= cnt_sum[k][CW-1:0];
            end
        end
    end
`else
    logic [NUM_K-1:0] acc_reg;

    assign pooled = acc_reg | bits;

    always_ff @(posedge clk) begin
        if (rst || clear || complete) begin
            acc_reg <= '0;
        end else if (accept) begin
            acc_reg <= pooled;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pool_cnt_reg  <= '0;
            win_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (clear) begin
                pool_cnt_reg <= '0;
                win_cnt_reg  <= '0;
            end else if (complete) begin
                pool_cnt_reg <= '0;
                win_cnt_reg  <= win_last ? '0 : win_cnt_reg + WCW'(1);
            end else if (accept) begin
                pool_cnt_reg <= pool_cnt_reg + PCW'(1);
            end

            // A pending vector survives clear; a new one may replace it in the cycle it is taken.
            if (complete) begin
                out_data_reg  <= pooled;
                out_last_reg  <= win_last;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    hold_stable: assert property (@(posedge clk)
        (!rst && out_valid_reg && !out_ready) |=>
            (out_valid_reg && $stable(out_data_reg) && $stable(out_last_reg)));

    pool_cnt_range: assert property (@(posedge clk) disable iff (rst)
        pool_cnt_reg <= PCW'(SAFE_POOL - 1));

endmodule

// File: tb/tb_bnn_sign_pool.sv
// Scoreboard bench for bnn_sign_pool: default instance plus POOL=1/THRESH=2 and POOL=3 instances.
`timescale 1ns/1ps

module tb_bnn_sign_pool;

    localparam int NK     = 3;
    localparam int SW     = 4;
    localparam int POOL   = 2;
    localparam int FRAMES = 6;
    localparam int WIN    = FRAMES / POOL;
`ifdef BNN_SIGN_POOL_MAJ_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic clk;
    logic rst;
    logic clear;
    logic in_valid;
    logic in_ready;
    logic [NK*SW-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [NK-1:0] out_data;
    logic out_last;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_clear;
    logic [NK*SW-1:0] a_in_data;
    logic [NK-1:0] a_out_data;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_clear;
    logic [NK*SW-1:0] b_in_data;
    logic [NK-1:0] b_out_data;

    int checks = 0;
    int errors = 0;

    logic [NK:0] exp_q[$];
    int m_pool;
    int m_win;
    int m_cnt[NK];
    logic [NK-1:0] m_acc;

    bnn_sign_pool #(.NUM_K(NK), .SUM_W(SW), .POOL(POOL), .FRAMES(FRAMES), .THRESH(0)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    bnn_sign_pool #(.NUM_K(NK), .SUM_W(SW), .POOL(1), .FRAMES(2), .THRESH(2)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
    );

    bnn_sign_pool #(.NUM_K(NK), .SUM_W(SW), .POOL(3), .FRAMES(6), .THRESH(0)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NK*SW-1:0] pack(input int k2, input int k1, input int k0);
        logic [SW-1:0] s2, s1, s0;
        s2 = k2[SW-1:0];
        s1 = k1[SW-1:0];
        s0 = k0[SW-1:0];
        return {s2, s1, s0};
    endfunction

    function automatic logic [NK-1:0] act(input logic [NK*SW-1:0] d, input int thr);
        logic [NK-1:0] b;
        for (int k = 0; k < NK; k++) begin
            b[k] = ($signed(d[k*SW +: SW]) >= thr);
        end
        return b;
    endfunction

    task automatic model_clear();
        m_pool = 0;
        m_win  = 0;
        m_acc  = '0;
        for (int k = 0; k < NK; k++) m_cnt[k] = 0;
    endtask

    task automatic model_accept(input logic [NK*SW-1:0] d, input logic clr);
        logic [NK-1:0] b;
        logic [NK-1:0] p;
        b = act(d, 0);
        if (clr) begin
            model_clear();
        end else if (m_pool == POOL - 1) begin
            for (int k = 0; k < NK; k++) begin
                p[k] = MAJ ? (2 * (m_cnt[k] + int'(b[k])) > POOL) : (m_acc[k] | b[k]);
            end
            exp_q.push_back({(m_win == WIN - 1), p});
            m_win = (m_win == WIN - 1) ? 0 : m_win + 1;
            m_pool = 0;
            m_acc = '0;
            for (int k = 0; k < NK; k++) m_cnt[k] = 0;
        end else begin
            m_acc = m_acc | b;
            for (int k = 0; k < NK; k++) m_cnt[k] += int'(b[k]);
            m_pool++;
        end
    endtask

    task automatic send_beat(input logic [NK*SW-1:0] d, output int waits);
        bit done;
        done = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, clear);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_clear(input bit with_beat, input logic [NK*SW-1:0] d);
        clear = 1'b1;
        in_valid = with_beat;
        in_data = d;
        @(negedge clk);
        model_clear();
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        exp_q.delete();
        model_clear();
        in_valid = 1'b0;
        clear = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 32'd0);
    endtask

    // Scoreboard: every transfer is matched against the oldest predicted vector.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            $display("out transfer data=%b last=%b", out_data, out_last);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [NK:0] e;
                e = exp_q.pop_front();
                check("sb_data", out_data, e[NK-1:0]);
                check("sb_last", out_last, e[NK]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [NK:0] snap;
        logic [NK-1:0] exp_b;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", out_last, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_a_valid", a_out_valid, 32'd0);
        check("rst_b_valid", b_out_valid, 32'd0);

        // Basic window: (+3,-1,-5) then (-3,-1,+1)
        send_beat(pack(3, -1, -5), w);
        send_beat(pack(-3, -1, 1), w);
        in_valid = 1'b0;
        check("t1_valid_rise", out_valid, 32'd1);
        if (!MAJ) check("t1_data_const", out_data, 32'b101);
        @(posedge clk);
        #1;
        check("t1_valid_drop", out_valid, 32'd0);
        drain("t1_sb_empty");

        // Full segment with continuous valid
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            send_beat(pack(1, 1, 1), w);
            check("t2_in_ready_stall", w, 32'd0);
        end
        in_valid = 1'b0;
        drain("t2_sb_empty");

        // Threshold edges at the signed extremes
        reset_dut();
        send_beat(pack(0, -1, 7), w);
        send_beat(pack(-8, -8, -8), w);
        in_valid = 1'b0;
        drain("t3_sb_empty");

        // Backpressure, clear during a pending vector, then recovery
        reset_dut();
        out_ready = 1'b0;
        send_beat(pack(1, -1, 1), w);
        send_beat(pack(-1, -1, -1), w);
        in_valid = 1'b1;
        in_data = pack(1, 1, 1);
        snap = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            clear = (i == 2);
            @(posedge clk);
            #1;
            if (i == 2) model_clear();
            check("bp_in_ready", in_ready, 32'd0);
            check("bp_valid", out_valid, 32'd1);
            check("bp_data", out_data, snap[NK-1:0]);
            check("bp_last", out_last, snap[NK]);
        end
        clear = 1'b0;
        out_ready = 1'b1;
        send_beat(pack(1, 1, 1), w);
        send_beat(pack(-1, -1, -1), w);
        in_valid = 1'b0;
        drain("t4_sb_empty");

        // Reset while a vector is pending discards it
        out_ready = 1'b0;
        send_beat(pack(1, 1, 1), w);
        send_beat(pack(1, 1, 1), w);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 32'd1);
        reset_dut();
        check("post_rst_valid", out_valid, 32'd0);
        check("post_rst_data", out_data, 32'd0);
        out_ready = 1'b1;

        // clear after one beat, then a full segment
        send_beat(pack(-1, -1, -1), w);
        in_valid = 1'b0;
        pulse_clear(1'b0, '0);
        send_beat(pack(1, 1, 1), w);
        send_beat(pack(-1, -1, -1), w);
        send_beat(pack(-1, 2, -1), w);
        send_beat(pack(-4, -1, 0), w);
        send_beat(pack(5, -2, -6), w);
        send_beat(pack(-7, 3, 4), w);
        in_valid = 1'b0;
        drain("t5_sb_empty");

        // clear with a beat in the same cycle: the beat is dropped
        send_beat(pack(1, 1, 1), w);
        in_valid = 1'b0;
        pulse_clear(1'b1, pack(1, 1, 1));
        send_beat(pack(-1, -1, -1), w);
        send_beat(pack(-1, -1, -1), w);
        in_valid = 1'b0;
        drain("t6_sb_empty");

        // POOL=1, THRESH=2: threshold edge and back-to-back reload
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = pack(1, 2, 3);
        @(posedge clk);
        #1;
        check("a_valid", a_out_valid, 32'd1);
        check("a_data_thr", a_out_data, 32'b011);
        check("a_last0", a_out_last, 32'd0);
        a_in_data = pack(2, 1, -8);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("a_hold_ready", a_in_ready, 32'd0);
            check("a_hold_data", a_out_data, 32'b011);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        check("a_b2b_valid", a_out_valid, 32'd1);
        check("a_b2b_data", a_out_data, 32'b100);
        check("a_b2b_last", a_out_last, 32'd1);
        @(posedge clk);
        #1;
        check("a_drop_valid", a_out_valid, 32'd0);

        // POOL=3: bits 110, 100, 011
        b_in_valid = 1'b1;
        b_in_data = pack(1, 1, -1);
        @(posedge clk);
        #1;
        b_in_data = pack(1, -1, -1);
        @(posedge clk);
        #1;
        b_in_data = pack(-1, 1, 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        exp_b = MAJ ? 3'b110 : 3'b111;
        check("b_valid", b_out_valid, 32'd1);
        check("b_data", b_out_data, exp_b);
        check("b_last", b_out_last, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_sign_pool.md
Name: bnn_sign_pool

Overview:
- Stage directly downstream of the binary convolution stage.
- Consumes one vector of per-kernel signed convolution sums per frame and applies sign activation against a threshold.
- Pools the activated bits over POOL consecutive frames.
- Emits one NUM_K-bit binary feature vector per pool window over a valid/ready handshake. Marks the last vector of each FRAMES-frame segment for the following dense/classifier stage.

Parameters:
- NUM_K, 3, number of kernels (channels).
- SUM_W, 4, width of each signed kernel sum (two's complement).
- POOL, 2, frames per pool window (>=1).
- FRAMES, 6, frames per segment; FRAMES % POOL must be 0, otherwise elaboration fails with $error.
- THRESH, 0, signed activation threshold (SUM_W bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  synchronous abort of the current segment.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_data  in  NUM_K*SUM_W  kernel k sum at [k*SUM_W +: SUM_W], signed.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_K  pooled binary features, bit k = kernel k.
- out_last  out  1  out_data is the final vector of a segment.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset values: out_valid=0, out_data=0, out_last=0, pool_cnt=0, frame_cnt=0, pool accumulator=0. in_ready=1 in the cycle after reset.
- Activation: bit_k = ($signed(sum_k) >= $signed(THRESH)). Full signed range applies, e.g. -8..+7 for SUM_W=4.
- in_ready = !out_valid || out_ready (combinational). No other stall source exists.
- On each accepted beat that is not the last of a pool window:
  - acc_k |= bit_k.
  - pool_cnt++.
- On an accepted beat with pool_cnt==POOL-1:
  - out_data <= acc | bits, so the current beat is included.
  - out_valid <= 1.
  - out_last <= (frame_cnt==FRAMES-1).
  - acc <= 0, pool_cnt <= 0.
  - frame_cnt <= (frame_cnt==FRAMES-1) ? 0 : frame_cnt+1.
- frame_cnt counts pool windows, range 0..FRAMES/POOL-1. out_last is asserted on the window index FRAMES/POOL-1. The comparison above uses the window count, not the raw frame count.
- Latency: out_valid rises the cycle after the completing beat is accepted.
- Output register:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - A transfer (out_valid && out_ready) clears out_valid, unless a completing beat is accepted in the same cycle. In that case the new vector loads and out_valid stays 1 (back-to-back throughput).
- POOL=1: every accepted beat produces an output.
- clear:
  - Zeroes acc, pool_cnt and frame_cnt, discarding the partial window/segment.
  - A pending output (out_valid=1) is NOT dropped; it completes normally.
  - Beat accepted in the same cycle as clear: the beat is consumed and discarded, and clear wins.
- rst mid-operation: all state, including a pending output, is discarded per the reset values.

Optional Feature:
- Macro: BNN_SIGN_POOL_MAJ_EN.
- Defined: majority pooling. A per-kernel count of ones, width $clog2(POOL+1), replaces the OR accumulator. out bit_k = (2*count_k > POOL); ties give 0. Counts clear under the same conditions as acc.
- Undefined: max pooling (bitwise OR) as above, and no counters are instantiated.

Test Plan:
- Defaults, rst then beats (k2,k1,k0): (+3,-1,-5) then (-3,-1,+1), out_ready=1 -> out_data=3'b101 one cycle after the 2nd accept, out_last=0, out_valid for one cycle.
- Six beats, all sums +1, continuous valid, out_ready=1 -> three vectors 3'b111; out_last=1 only on the third; in_ready stays 1 throughout.
- Threshold edges: sums (0,-1,+7) then (-8,-8,-8) -> out_data=3'b101. With THRESH=2: sum 1 -> bit 0, sum 2 -> bit 1.
- Backpressure: out_ready=0 while a vector is pending -> in_ready=0, out_data/out_last stable for 5 cycles. Raising out_ready with a completing beat pending -> the new vector loads the next cycle and out_valid stays 1.
- clear asserted after 1 accepted beat of window 0 -> the next 2 beats (+1,+1,+1),(-1,-1,-1) yield out_data=3'b111 with out_last=0. The third window after clear gives out_last=1.
- BNN_SIGN_POOL_MAJ_EN, POOL=3, FRAMES=6: bits per beat 3'b110, 3'b100, 3'b011 -> out_data=3'b110. Without the macro -> 3'b111.
